// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: I2S transmitter for a mono 16-bit signed sample that is duplicated onto both channels.
//   It derives bclk and lrclk from sysClk and shifts each frame out MSB first with the I2S one-bit delay.
//   It pulses frameStart once per frame so the upstream generator can use it as its sample-rate tick.
// Ports:
//   sysClk, reset (synchronous, active-high)
//   sampleData/sampleValid   sample input, written into a one-deep holding register
//   statusClr                clears the underrun/overrun sticky flags (a same-cycle set wins)
//   bclk, lrclk, sdata       registered I2S outputs; sdata changes only on bclk falling edges
//   frameStart               one-cycle pulse on every frame load
//   underrun, overrun        sticky status flags
// Optional feature: define I2S_UNDERRUN_REPEAT_EN to repeat the last sample on underrun
//   (default build sends silence).
module i2s_audio_tx #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 16
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic [15:0] sampleData,
  input  logic        sampleValid,
  input  logic        statusClr,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        frameStart,
  output logic        underrun,
  output logic        overrun
);

  localparam int FW = 2 * SLOT_BITS;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(FW);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(SLOT_BITS);

  logic [DW-1:0] divCnt_q, divCnt_d;
  logic [BW-1:0] bitCnt_q, bitCnt_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic [15:0]   hold_q, hold_d;
  logic          full_q, full_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          frameStart_q, frameStart_d;
  logic          underrun_q, underrun_d;
  logic          overrun_q, overrun_d;
`ifdef I2S_UNDERRUN_REPEAT_EN
  logic [15:0]   last_q, last_d;
`endif

  logic          div_tc;
  logic          fall_ev;
  logic [BW-1:0] bit_nxt;
  logic          load;
  logic [15:0]   sel;
  logic [FW-1:0] frame_w;
  logic          set_ur;
  logic          set_or;

  assign div_tc  = (divCnt_q == DIV_LAST);
  // Falling edge of bclk: the only moment the serial state advances.
  assign fall_ev = bclk_q && div_tc;
  assign bit_nxt = (bitCnt_q == BIT_LAST) ? '0 : bitCnt_q + 1'b1;
  assign load    = fall_ev && (bit_nxt == '0);

  // Sample chosen for the frame. This is only meaningful when load is asserted.
  always_comb begin
    sel = 16'h0000;
    if (full_q) begin
      sel = hold_q;
    end else if (sampleValid) begin
      sel = sampleData;               // bypass: fresh sample arrives exactly at load
    end else begin
`ifdef I2S_UNDERRUN_REPEAT_EN
      sel = last_q;
`else
      sel = 16'h0000;
`endif
    end
  end

  // Each slot holds the sample MSB-aligned, with zero padding below it.
  always_comb begin
    frame_w = '0;
    frame_w[FW-1 -: 16]        = sel;
    frame_w[SLOT_BITS-1 -: 16] = sel;
  end

  always_comb begin
    divCnt_d     = div_tc ? '0 : divCnt_q + 1'b1;
    bclk_d       = bclk_q ^ div_tc;
    bitCnt_d     = bitCnt_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    shreg_d      = shreg_q;
    frameStart_d = load;
    hold_d       = hold_q;
    full_d       = full_q;
    set_ur       = 1'b0;
    set_or       = 1'b0;
`ifdef I2S_UNDERRUN_REPEAT_EN
    last_d       = load ? sel : last_q;
`endif

    // sdata takes the old MSB before the shift. This gives the one-bit I2S delay
    // relative to lrclk.
    if (fall_ev) begin
      bitCnt_d = bit_nxt;
      lrclk_d  = (bit_nxt >= BIT_HALF);
      sdata_d  = shreg_q[FW-1];
      shreg_d  = load ? frame_w : (shreg_q << 1);
    end

    if (load) begin
      if (full_q) begin
        // A refill on the load cycle replaces the consumed sample, so it is not an overrun.
        if (sampleValid) hold_d = sampleData;
        else             full_d = 1'b0;
      end else if (!sampleValid) begin
        set_ur = 1'b1;
      end
    end else if (sampleValid) begin
      hold_d = sampleData;
      full_d = 1'b1;
      set_or = full_q;
    end

    underrun_d = (underrun_q && !statusClr) || set_ur;
    overrun_d  = (overrun_q  && !statusClr) || set_or;
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      divCnt_q     <= '0;
      bitCnt_q     <= BIT_LAST;
      shreg_q      <= '0;
      hold_q       <= '0;
      full_q       <= 1'b0;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b1;
      sdata_q      <= 1'b0;
      frameStart_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef I2S_UNDERRUN_REPEAT_EN
      last_q       <= '0;
`endif
    end else begin
      divCnt_q     <= divCnt_d;
      bitCnt_q     <= bitCnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      full_q       <= full_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      frameStart_q <= frameStart_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
`ifdef I2S_UNDERRUN_REPEAT_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign frameStart = frameStart_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

endmodule
